// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back through a shared ALU and one unified memory.
module multicycle_control #(
   parameter logic [5:0] OP_RTYPE = 6'b000000,
   parameter logic [5:0] OP_LW    = 6'b100011,
   parameter logic [5:0] OP_SW    = 6'b101011,
   parameter logic [5:0] OP_BEQ   = 6'b000100,
   parameter logic [5:0] OP_J     = 6'b000010,
   parameter logic [5:0] OP_ADDI  = 6'b001000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       jr_enable,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH     = 4'd0,
      DECODE    = 4'd1,
      MEM_ADDR  = 4'd2,
      MEM_READ  = 4'd3,
      MEM_WB    = 4'd4,
      MEM_WRITE = 4'd5,
      R_EXEC    = 4'd6,
      R_WB      = 4'd7,
      BRANCH    = 4'd8,
      JUMP      = 4'd9,
      ADDI_EXEC = 4'd10,
      ADDI_WB   = 4'd11
   } state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal_op;
   } ctrl_t;

   state_t state_q;
   state_t state_d;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;

   logic op_is_lw;
   logic op_is_sw;
   logic op_is_rtype;
   logic op_is_beq;
   logic op_is_j;
   logic op_is_addi;
   logic op_known;

   assign op_is_lw    = (opcode == OP_LW);
   assign op_is_sw    = (opcode == OP_SW);
   assign op_is_rtype = (opcode == OP_RTYPE);
   assign op_is_beq   = (opcode == OP_BEQ);
   assign op_is_j     = (opcode == OP_J);
   assign op_is_addi  = (opcode == OP_ADDI);
   assign op_known    = op_is_lw | op_is_sw | op_is_rtype | op_is_beq | op_is_j | op_is_addi;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = FETCH;
      case (state_q)
         FETCH:     state_d = mem_ready ? DECODE : FETCH;
         DECODE: begin
            if (op_is_lw || op_is_sw) state_d = MEM_ADDR;
            else if (op_is_rtype)     state_d = R_EXEC;
            else if (op_is_beq)       state_d = BRANCH;
            else if (op_is_j)         state_d = JUMP;
            else if (op_is_addi)      state_d = ADDI_EXEC;
            else                      state_d = FETCH;
         end
         MEM_ADDR: begin
            if (op_is_lw)      state_d = MEM_READ;
            else if (op_is_sw) state_d = MEM_WRITE;
            else               state_d = FETCH;
         end
         MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
         MEM_WB:    state_d = FETCH;
         MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
         R_EXEC:    state_d = jr_enable ? FETCH : R_WB;
         R_WB:      state_d = FETCH;
         BRANCH:    state_d = FETCH;
         JUMP:      state_d = FETCH;
         ADDI_EXEC: state_d = ADDI_WB;
         ADDI_WB:   state_d = FETCH;
         default:   state_d = FETCH;
      endcase
   end

   // Moore decode of the current state; mem_ready only gates the FETCH loads.
   always_comb begin
      ctrl = '0;
      case (state_q)
         FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = 2'b01;
            ctrl.ir_write  = mem_ready;
            ctrl.pc_write  = mem_ready;
         end
         DECODE: begin
            ctrl.alu_src_b  = 2'b11;
            ctrl.illegal_op = ~op_known;
         end
         MEM_ADDR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         MEM_READ: begin
            ctrl.mem_read = 1'b1;
            ctrl.i_or_d   = 1'b1;
         end
         MEM_WB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         MEM_WRITE: begin
            ctrl.mem_write = 1'b1;
            ctrl.i_or_d    = 1'b1;
         end
         R_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = 2'b10;
            if (jr_enable) begin
               ctrl.pc_write  = 1'b1;
               ctrl.pc_source = 2'b11;
            end
         end
         R_WB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = 2'b01;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_source     = 2'b01;
         end
         JUMP: begin
            ctrl.pc_write  = 1'b1;
            ctrl.pc_source = 2'b10;
         end
         ADDI_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = 2'b10;
         end
         ADDI_WB: begin
            ctrl.reg_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   // Outputs are forced low for the whole time reset is held, not just after an edge.
   assign ctrl_out = reset ? ctrl : '0;

   assign pc_write      = ctrl_out.pc_write;
   assign pc_write_cond = ctrl_out.pc_write_cond;
   assign i_or_d        = ctrl_out.i_or_d;
   assign mem_read      = ctrl_out.mem_read;
   assign mem_write     = ctrl_out.mem_write;
   assign ir_write      = ctrl_out.ir_write;
   assign mem_to_reg    = ctrl_out.mem_to_reg;
   assign reg_dst       = ctrl_out.reg_dst;
   assign reg_write     = ctrl_out.reg_write;
   assign alu_src_a     = ctrl_out.alu_src_a;
   assign alu_src_b     = ctrl_out.alu_src_b;
   assign alu_op        = ctrl_out.alu_op;
   assign pc_source     = ctrl_out.pc_source;
   assign illegal_op    = ctrl_out.illegal_op;
   assign state         = state_q;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sequences one instruction over 3–5 cycles through the shared ALU, register file and single unified memory. It drives the datapath mux selects, write enables and the 2-bit ALUOp consumed by the ALU control decoder, and it receives that decoder's jr flag back. A ready handshake stalls memory-access states.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-equal opcode
OP_J, 6'b000010, jump opcode
OP_ADDI, 6'b001000, add-immediate opcode

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
opcode  input  6  IR[31:26], valid from DECODE onward
jr_enable  input  1  from ALU control; high when funct = 001000 and ALUOp = 10
mem_ready  input  1  memory completes the access this cycle
pc_write  output  1  unconditional PC load
pc_write_cond  output  1  PC load if ALU zero (beq)
i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
ir_write  output  1  instruction register load
mem_to_reg  output  1  write-back select: 1 = MDR, 0 = ALUOut
reg_dst  output  1  destination select: 1 = rd, 0 = rt
reg_write  output  1  register file write enable
alu_src_a  output  1  0 = PC, 1 = rs
alu_src_b  output  2  00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
alu_op  output  2  00 = add, 01 = sub, 10 = funct-decoded
pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = rs (jr)
illegal_op  output  1  one-cycle pulse on an unknown opcode
state  output  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, R_EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EXEC = 10, ADDI_WB = 11.
- Reset: while reset is low, state = FETCH and all outputs = 0. This takes effect immediately, without a clock edge. A reset mid-instruction aborts it with no partial write. The first FETCH outputs appear after reset deasserts.
- Outputs are decoded from state only, plus mem_ready gating. Every signal not listed for a state is 0.
- FETCH:
  - Drives mem_read = 1, i_or_d = 0, alu_src_a = 0, alu_src_b = 01, alu_op = 00, pc_source = 00.
  - ir_write and pc_write are 1 only when mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE when it is 1.
- DECODE:
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = 00 (precomputes the branch target).
  - Next state: lw/sw → MEM_ADDR; R-type → R_EXEC; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Any other opcode: pulse illegal_op = 1 this cycle, next state = FETCH.
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next is FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Holds until mem_ready = 1, then goes to FETCH. mem_write stays high for every stall cycle.
- R_EXEC: alu_src_a = 1, alu_src_b = 00, alu_op = 10.
  - If jr_enable = 1: pc_write = 1, pc_source = 11, next state = FETCH (no register write).
  - Otherwise next state = R_WB.
- R_WB: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Next is FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_write_cond = 1, pc_source = 01. Next is FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next is FETCH.
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 00. Next is ADDI_WB.
- ADDI_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next is FETCH.
- Invariants:
  - mem_read and mem_write are never both 1.
  - reg_write and any PC write are never both 1.
  - Unused state encodings 12–15 go to FETCH and assert no enables.
- Latency with mem_ready always 1, in cycles: lw 5, sw 4, R-type 4, jr 3, addi 4, beq 3, j 3. Each cycle with mem_ready = 0 adds exactly 1 cycle.
- opcode is sampled only in DECODE and MEM_ADDR. jr_enable is sampled only in R_EXEC.

Test Plan:
- Reset low mid-MEM_READ (state = 3) → all outputs 0 and state = 0 immediately, no clock. Release → FETCH with mem_read = 1, ir_write = 0 until mem_ready = 1.
- lw (100011), mem_ready = 1 → state sequence 0, 1, 2, 3, 4, 0. reg_write = 1 with mem_to_reg = 1 only in state 4.
- sw (101011), mem_ready held 0 for 3 cycles in MEM_WRITE → mem_write = 1 for 4 cycles, then FETCH. Total instruction = 7 cycles.
- R-type with jr_enable = 0 → R_WB with reg_dst = 1. Same with jr_enable = 1 → pc_write = 1 and pc_source = 11 in R_EXEC, no reg_write, back to FETCH after 3 cycles.
- beq (000100) → BRANCH with alu_op = 01, pc_write_cond = 1, pc_source = 01. j (000010) → pc_write = 1, pc_source = 10.
- opcode 111111 → illegal_op pulses for 1 cycle in DECODE, next state = FETCH, no write enable asserted.
